mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 47 ++++
 rtl/mem_lsu_if.sv | 60 ++++++
 rtl/mem_lsu_align.sv | 62 ++++++
 rtl/mem_lsu.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types for the memory-stage load/store unit: FSM states,
// RISC-V load/store func3 codes, size strobes and size helpers.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  function automatic logic [7:0] size_strb(
    input logic [1:0] sz
  );
    unique case (sz)
      2'd0:    size_strb = STRB_B;
      2'd1:    size_strb = STRB_H;
      2'd2:    size_strb = STRB_W;
      default: size_strb = STRB_D;
    endcase
  endfunction

  // byte-offset bits that must be zero for a natural alignment
  function automatic logic [2:0] size_lsb(
    input logic [1:0] sz
  );
    unique case (sz)
      2'd0:    size_lsb = 3'd0;
      2'd1:    size_lsb = 3'd1;
      2'd2:    size_lsb = 3'd3;
      default: size_lsb = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Memory-stage request, data-bus and writeback signals of the LSU.
// master: pipeline/bus side; slave: the LSU (mem_lsu).
interface mem_lsu_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_ren_i;
  logic              req_wen_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic [2:0]        req_func3_i;
  logic [4:0]        req_rd_waddr_i;
  logic [XLEN-1:0]   req_rd_wdata_i;
  logic              req_reg_wen_i;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [XLEN-1:0]   bus_wdata_o;
  logic [XLEN/8-1:0] bus_wstrb_o;
  logic              bus_gnt_i;
  logic              bus_rvalid_i;
  logic [XLEN-1:0]   bus_rdata_i;

  logic              wb_valid_o;
  logic [4:0]        rd_waddr_o;
  logic [XLEN-1:0]   rd_wdata_o;
  logic              reg_wen_o;
  logic              stall_o;
  logic              misalign_o;

  modport master (
    output req_valid_i, req_ren_i, req_wen_i,
    output req_addr_i, req_wdata_i, req_func3_i,
    output req_rd_waddr_i, req_rd_wdata_i,
    output req_reg_wen_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  req_ready_o,
    input  bus_req_o, bus_we_o, bus_addr_o,
    input  bus_wdata_o, bus_wstrb_o,
    input  wb_valid_o, rd_waddr_o, rd_wdata_o,
    input  reg_wen_o, stall_o, misalign_o
  );

  modport slave (
    input  req_valid_i, req_ren_i, req_wen_i,
    input  req_addr_i, req_wdata_i, req_func3_i,
    input  req_rd_waddr_i, req_rd_wdata_i,
    input  req_reg_wen_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output req_ready_o,
    output bus_req_o, bus_we_o, bus_addr_o,
    output bus_wdata_o, bus_wstrb_o,
    output wb_valid_o, rd_waddr_o, rd_wdata_o,
    output reg_wen_o, stall_o, misalign_o
  );

endinterface

// File: rtl/mem_lsu_align.sv
// lsu_align: store shift/strobe, load shift/extend, alignment check.
// LSU_MISALIGN_EXC_EN: flag misaligned ops (else mis=0, offset truncated).
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter  int XLEN = 64,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic [2:0]      func3,
  input  logic [OW-1:0]   off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [OW-1:0]   off_eff,
  output logic            mis,
  output logic [XLEN-1:0] wdata_sh,
  output logic [NB-1:0]   wstrb,
  output logic [XLEN-1:0] rdata_ext
);
  logic [7:0]      m;
  logic [NB-1:0]   m_n;
  logic [2:0]      lsb;
  logic [OW-1:0]   lsb_n;
  logic [XLEN-1:0] rs;
  logic [63:0]     r;
  logic [63:0]     ext;

  assign m     = size_strb(func3[1:0]);
  assign m_n   = m[NB-1:0];
  assign lsb   = size_lsb(func3[1:0]);
  assign lsb_n = lsb[OW-1:0];

  assign off_eff = off & ~lsb_n;
`ifdef LSU_MISALIGN_EXC_EN
  assign mis = |(off & lsb_n);
`else
  assign mis = 1'b0;
`endif

  assign wdata_sh = wdata << {off_eff, 3'b000};
  assign wstrb    = m_n << off_eff;

  assign rs = rdata >> {off_eff, 3'b000};
  assign r  = 64'(rs);

  always_comb begin
    ext = '0;
    unique case (func3)
      F3_B:  ext = {{56{r[7]}}, r[7:0]};
      F3_H:  ext = {{48{r[15]}}, r[15:0]};
      F3_W:  ext = {{32{r[31]}}, r[31:0]};
      F3_D:  ext = (XLEN == 64) ? r : '0;
      F3_BU: ext = {56'b0, r[7:0]};
      F3_HU: ext = {48'b0, r[15:0]};
      F3_WU: ext = (XLEN == 64) ? {32'b0, r[31:0]} : '0;
      default: ext = '0;
    endcase
  end

  assign rdata_ext = ext[XLEN-1:0];

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage LSU FSM (IDLE/REQ/RESP), bus regs, writeback.
// Ports: clk, rst (sync, low), lsu (mem_lsu_if.slave). Macro LSU_MISALIGN_EXC_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input logic      clk,
  input logic      rst,
  mem_lsu_if.slave lsu
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_e        state;
  logic [2:0]        f3_q;
  logic [OW-1:0]     off_q;
  logic              rwen_q;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [NB-1:0]     bus_wstrb;
  logic              wb_valid;
  logic [4:0]        rd_waddr;
  logic [XLEN-1:0]   rd_wdata;
  logic              reg_wen;
  logic              mis_q;

  logic              idle;
  logic              mem_op;
  logic [2:0]        f3_s;
  logic [OW-1:0]     off_s;
  logic [OW-1:0]     off_eff;
  logic              mis;
  logic [XLEN-1:0]   wdata_sh;
  logic [NB-1:0]     wstrb;
  logic [XLEN-1:0]   rdata_ext;

  assign idle   = (state == IDLE);
  assign mem_op = lsu.req_ren_i | lsu.req_wen_i;
  // IDLE aligns the new request; later states decode the latched op
  assign f3_s   = idle ? lsu.req_func3_i : f3_q;
  assign off_s  = idle ? lsu.req_addr_i[OW-1:0] : off_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .func3     (f3_s),
    .off       (off_s),
    .wdata     (lsu.req_wdata_i),
    .rdata     (lsu.bus_rdata_i),
    .off_eff   (off_eff),
    .mis       (mis),
    .wdata_sh  (wdata_sh),
    .wstrb     (wstrb),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      rwen_q    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      wb_valid  <= 1'b0;
      rd_waddr  <= '0;
      rd_wdata  <= '0;
      reg_wen   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      reg_wen  <= 1'b0;
      mis_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lsu.req_valid_i) begin
            rd_waddr <= lsu.req_rd_waddr_i;
            rwen_q   <= lsu.req_reg_wen_i;
            f3_q     <= lsu.req_func3_i;
            off_q    <= off_eff;
            if (!mem_op) begin
              wb_valid <= 1'b1;
              rd_wdata <= lsu.req_rd_wdata_i;
              reg_wen  <= lsu.req_reg_wen_i;
            end else if (mis) begin
              wb_valid <= 1'b1;
              rd_wdata <= '0;
              mis_q    <= 1'b1;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= lsu.req_wen_i;
              bus_addr  <= {lsu.req_addr_i[ADDR_W-1:OW],
                            {OW{1'b0}}};
              bus_wdata <= wdata_sh;
              bus_wstrb <= wstrb;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (lsu.bus_gnt_i) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (bus_we) begin
              state    <= IDLE;
              wb_valid <= 1'b1;
              rd_wdata <= '0;
            end else if (lsu.bus_rvalid_i) begin
              state    <= IDLE;
              wb_valid <= 1'b1;
              rd_wdata <= rdata_ext;
              reg_wen  <= rwen_q;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (lsu.bus_rvalid_i) begin
            state    <= IDLE;
            wb_valid <= 1'b1;
            rd_wdata <= rdata_ext;
            reg_wen  <= rwen_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu.req_ready_o = idle;
  assign lsu.stall_o     = ~idle |
    (lsu.req_valid_i & mem_op & idle);
  assign lsu.bus_req_o   = bus_req;
  assign lsu.bus_we_o    = bus_we;
  assign lsu.bus_addr_o  = bus_addr;
  assign lsu.bus_wdata_o = bus_wdata;
  assign lsu.bus_wstrb_o = bus_wstrb;
  assign lsu.wb_valid_o  = wb_valid;
  assign lsu.rd_waddr_o  = rd_waddr;
  assign lsu.rd_wdata_o  = rd_wdata;
  assign lsu.reg_wen_o   = reg_wen;
  assign lsu.misalign_o  = mis_q;

endmodule
